alu8_seq: RTL



---
 rtl/alu8_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu8_seq.sv
// 8-bit ALU sequencer: runs one external 4-bit slice twice
// (low nibble, then high nibble) and assembles result and flags.
module alu8_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] op_s,
  input  logic       op_m,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       co,
  output logic       hc,
  output logic       zero,
  output logic       neg,
  output logic [3:0] sa,
  output logic [3:0] sb,
  output logic       sci,
  output logic       sm,
  output logic [3:0] ss,
  input  logic [3:0] sf,
  input  logic       sg,
  input  logic       sp
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       ci_q, ci_d;
  logic       m_q, m_d;
  logic [3:0] s_q, s_d;
  logic       c4_q, c4_d;
  logic [3:0] lo_q, lo_d;
  logic [7:0] result_q, result_d;
  logic       co_q, co_d;
  logic       hc_q, hc_d;
  logic       zero_q, zero_d;
  logic       neg_q, neg_d;
  logic [3:0] sa_w, sb_w;
  logic       sci_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ci_q     <= 1'b0;
      m_q      <= 1'b0;
      s_q      <= '0;
      c4_q     <= 1'b0;
      lo_q     <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      hc_q     <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      m_q      <= m_d;
      s_q      <= s_d;
      c4_q     <= c4_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      co_q     <= co_d;
      hc_q     <= hc_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ci_d     = ci_q;
    m_d      = m_q;
    s_d      = s_q;
    c4_d     = c4_q;
    lo_d     = lo_q;
    result_d = result_q;
    co_d     = co_q;
    hc_d     = hc_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    sa_w     = '0;
    sb_w     = '0;
    sci_w    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ci_d    = ci;
          m_d     = op_m;
          s_d     = op_s;
          state_d = LO;
        end
      end
      LO: begin
        sa_w    = a_q[3:0];
        sb_w    = b_q[3:0];
        sci_w   = ci_q & m_q;
        lo_d    = sf;
        c4_d    = m_q & (sg | (sp & sci_w));
        state_d = HI;
      end
      HI: begin
        sa_w     = a_q[7:4];
        sb_w     = b_q[7:4];
        sci_w    = c4_q;
        // Visible result and all flags move together, only here.
        result_d = {sf, lo_q};
        co_d     = m_q & (sg | (sp & c4_q));
        hc_d     = c4_q;
        zero_d   = ({sf, lo_q} == 8'h00);
        neg_d    = sf[3];
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign co     = co_q;
  assign hc     = hc_q;
  assign zero   = zero_q;
  assign neg    = neg_q;
  assign sa     = sa_w;
  assign sb     = sb_w;
  assign sci    = sci_w;
  assign sm     = m_q;
  assign ss     = s_q;

endmodule
